// File: rtl/io_ccff_chain_loader.sv
// io_ccff_chain_loader: serializes bitstream words into the I/O-tile config chain (LOAD),
// or recirculates the chain while counting tail mismatches against a re-sent stream (VERIFY).
module io_ccff_chain_loader #(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8,
    parameter int ERR_W     = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              err_flag
);
    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int WW = $clog2(WORD_W + 1);
    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
    state_t            r_state;
    logic              r_verify, r_ready, r_shift, r_busy, r_done, r_flag;
    logic [WORD_W-1:0] r_sr;
    logic [BW-1:0]     r_bits_left;
    logic [WW-1:0]     r_word_left;
    logic [ERR_W-1:0]  r_err;
    logic              w_msb, w_mis;
    logic [WW-1:0]     w_take;
    logic [ERR_W-1:0]  w_err_next;
    assign w_msb      = r_sr[WORD_W-1];
    assign w_mis      = r_verify & r_shift & (ccff_tail != w_msb);
    assign w_take     = (int'(r_bits_left) < WORD_W) ? WW'(r_bits_left) : WW'(WORD_W);
    assign w_err_next = (w_mis && r_err != '1) ? r_err + ERR_W'(1) : r_err;
    // VERIFY feeds the tail straight back so the chain is unchanged after a full pass
    assign ccff_head     = r_shift & (r_verify ? ccff_tail : w_msb);
    assign ccff_shift_en = r_shift;
    assign s_ready       = r_ready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err_cnt       = r_err;
    assign err_flag      = r_flag;
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_shift <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= '0;
            r_flag  <= 1'b0;
        end else if (abort && r_state != IDLE) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_shift <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state     <= FETCH;
                    r_verify    <= verify;
                    r_bits_left <= BW'(CHAIN_LEN);
                    r_ready     <= 1'b1;
                    r_busy      <= 1'b1;
                    if (verify) begin
                        r_err  <= '0;
                        r_flag <= 1'b0;
                    end
                end
                FETCH: if (s_valid) begin
                    r_state     <= SHIFT;
                    r_sr        <= s_data;
                    r_word_left <= w_take;
                    r_ready     <= 1'b0;
                    r_shift     <= 1'b1;
                end
                SHIFT: begin
                    r_sr        <= r_sr << 1;
                    r_bits_left <= r_bits_left - BW'(1);
                    r_word_left <= r_word_left - WW'(1);
                    r_err       <= w_err_next;
                    r_flag      <= |w_err_next;
                    if (r_bits_left == BW'(1)) begin
                        r_state <= DONE;
                        r_shift <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_word_left == WW'(1)) begin
                        r_state <= FETCH;
                        r_shift <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
